// File: rtl/ula_seq_if.sv
// Operand/result bundle between the control FSM (master) and the sequential ALU (slave).
interface ula_seq_if #(parameter int WIDTH = 16);
  logic             Start;
  logic [3:0]       Ulaop;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] BusWires;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Rem;
  logic             Done;
  logic             Busy;
  logic             Zero;
  logic             Neg;
  logic             Carry;
  logic             DivZero;

  modport master (output Start, Ulaop, A, BusWires,
                  input  Q, Rem, Done, Busy, Zero, Neg, Carry, DivZero);
  modport slave  (input  Start, Ulaop, A, BusWires,
                  output Q, Rem, Done, Busy, Zero, Neg, Carry, DivZero);
endinterface

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops, and iterative
// shift-add MUL and restoring DIV.  Results and flags are registered and held until the next Done.
module ula_seq #(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input logic   Clock,
   input logic   Reset,
   ula_seq_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_SLT = 4'h2, OP_CMP = 4'h3,
                          OP_ADDK = 4'h4, OP_SUBK = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7,
                          OP_XOR = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_SLTS = 4'hB,
                          OP_MUL = 4'hC, OP_DIV = 4'hD;

   typedef enum logic {IDLE, ITER} state_t;

   state_t           state, state_n;
   logic [SW-1:0]    cnt, cnt_n;
   logic [3:0]       op_r, op_n;
   logic [WIDTH-1:0] opd, opd_n, hi, hi_n, lo, lo_n;
   logic             busy_r, busy_n;
   logic [WIDTH-1:0] q_r, rem_r;
   logic             done_r, zero_r, neg_r, carry_r, dz_r;

   logic             wr, wc, wdz;
   logic [WIDTH-1:0] wq, wrem;

   // Single-cycle datapath
   logic [SW-1:0]    sh;
   logic [WIDTH:0]   add_w, sub_w, addk_w, subk_w, shl_w, shr_w;
   logic [WIDTH-1:0] s_q, s_rem;
   logic             s_c, s_dz;

   assign sh     = bus.BusWires[SW-1:0];
   assign add_w  = {1'b0, bus.A} + {1'b0, bus.BusWires};
   assign sub_w  = {1'b0, bus.A} - {1'b0, bus.BusWires};
   assign addk_w = {1'b0, bus.BusWires} + (WIDTH+1)'(STEP);
   assign subk_w = {1'b0, bus.BusWires} - (WIDTH+1)'(STEP);
   // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
   assign shl_w  = {1'b0, bus.A} << sh;
   assign shr_w  = {bus.A, 1'b0} >> sh;

   always_comb begin
      s_q   = '0;
      s_rem = '0;
      s_c   = 1'b0;
      s_dz  = 1'b0;
      case (bus.Ulaop)
         OP_ADD:  begin s_q = add_w[WIDTH-1:0];  s_c = add_w[WIDTH];  end
         OP_SUB:  begin s_q = sub_w[WIDTH-1:0];  s_c = sub_w[WIDTH];  end
         OP_SLT:  s_q = WIDTH'(sub_w[WIDTH]);
         OP_CMP:  s_q = WIDTH'(bus.A == bus.BusWires);
         OP_ADDK: begin s_q = addk_w[WIDTH-1:0]; s_c = addk_w[WIDTH]; end
         OP_SUBK: begin s_q = subk_w[WIDTH-1:0]; s_c = subk_w[WIDTH]; end
         OP_AND:  s_q = bus.A & bus.BusWires;
         OP_OR:   s_q = bus.A | bus.BusWires;
         OP_XOR:  s_q = bus.A ^ bus.BusWires;
         OP_SHL:  begin s_q = shl_w[WIDTH-1:0];  s_c = shl_w[WIDTH];  end
         OP_SHR:  begin s_q = shr_w[WIDTH:1];    s_c = shr_w[0];      end
         OP_SLTS: s_q = WIDTH'($signed(bus.A) < $signed(bus.BusWires));
         OP_DIV:  begin s_q = '1; s_rem = bus.A; s_dz = 1'b1; end
         default: ;
      endcase
   end

   // One MUL step: {hi,lo} holds partial product and remaining multiplier bits.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
   assign mul_hi  = mul_sum[WIDTH:1];
   assign mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};

   // One DIV step: hi is the partial remainder (< divisor), lo shifts dividend out / quotient in.
   logic [WIDTH:0]   div_sh, div_df;
   logic [WIDTH-1:0] div_hi, div_lo;
   assign div_sh = {hi, lo[WIDTH-1]};
   assign div_df = div_sh - {1'b0, opd};
   assign div_hi = div_df[WIDTH] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0];
   assign div_lo = {lo[WIDTH-2:0], ~div_df[WIDTH]};

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      op_n    = op_r;
      opd_n   = opd;
      hi_n    = hi;
      lo_n    = lo;
      busy_n  = busy_r;
      wr      = 1'b0;
      wq      = '0;
      wrem    = '0;
      wc      = 1'b0;
      wdz     = 1'b0;
      case (state)
         IDLE: if (bus.Start) begin
            op_n = bus.Ulaop;
            if (bus.Ulaop == OP_MUL || (bus.Ulaop == OP_DIV && bus.BusWires != '0)) begin
               state_n = ITER;
               cnt_n   = SW'(WIDTH-1);
               busy_n  = 1'b1;
               hi_n    = '0;
               opd_n   = (bus.Ulaop == OP_MUL) ? bus.A : bus.BusWires;
               lo_n    = (bus.Ulaop == OP_MUL) ? bus.BusWires : bus.A;
            end else begin
               wr   = 1'b1;
               wq   = s_q;
               wrem = s_rem;
               wc   = s_c;
               wdz  = s_dz;
            end
         end
         ITER: begin
            hi_n  = (op_r == OP_MUL) ? mul_hi : div_hi;
            lo_n  = (op_r == OP_MUL) ? mul_lo : div_lo;
            cnt_n = cnt - SW'(1);
            if (cnt == '0) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               wr      = 1'b1;
               wq      = lo_n;
               wrem    = hi_n;
               wc      = (op_r == OP_MUL) && (hi_n != '0);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_r    <= '0;
         opd     <= '0;
         hi      <= '0;
         lo      <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         q_r     <= '0;
         rem_r   <= '0;
         zero_r  <= 1'b0;
         neg_r   <= 1'b0;
         carry_r <= 1'b0;
         dz_r    <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         op_r   <= op_n;
         opd    <= opd_n;
         hi     <= hi_n;
         lo     <= lo_n;
         busy_r <= busy_n;
         done_r <= wr;
         if (wr) begin
            q_r     <= wq;
            rem_r   <= wrem;
            zero_r  <= (wq == '0);
            neg_r   <= wq[WIDTH-1];
            carry_r <= wc;
            dz_r    <= wdz;
         end
      end
   end

   assign bus.Q       = q_r;
   assign bus.Rem     = rem_r;
   assign bus.Done    = done_r;
   assign bus.Busy    = busy_r;
   assign bus.Zero    = zero_r;
   assign bus.Neg     = neg_r;
   assign bus.Carry   = carry_r;
   assign bus.DivZero = dz_r;
endmodule

// File: tb/tb_ula_seq.sv
// Randomized + directed bench for ula_seq (WIDTH=16, STEP=4) against an arithmetic reference model.
module tb_ula_seq;
  localparam int W = 16;
  localparam int STEP = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int failures = 0;

  ula_seq_if #(.WIDTH(W)) bus ();
  ula_seq #(.WIDTH(W), .STEP(STEP)) dut (.Clock(Clock), .Reset(Reset), .bus(bus.slave));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: returns {dz, c, rem[15:0], q[15:0]}
  function automatic logic [33:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ua = a, ub = b, p;
    longint q = 0, r = 0;
    int s = b[3:0];
    bit c = 0, dz = 0;
    case (op)
      4'h0: begin q = ua + ub; c = q > 65535; end
      4'h1: begin q = ua - ub; c = ua < ub; end
      4'h2: q = (ua < ub) ? 1 : 0;
      4'h3: q = (ua == ub) ? 1 : 0;
      4'h4: begin q = ub + STEP; c = q > 65535; end
      4'h5: begin q = ub - STEP; c = ub < STEP; end
      4'h6: q = ua & ub;
      4'h7: q = ua | ub;
      4'h8: q = ua ^ ub;
      4'h9: begin q = ua << s; c = (s != 0) && (((ua >> (16 - s)) & 1) != 0); end
      4'hA: begin q = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      4'hB: q = ($signed(a) < $signed(b)) ? 1 : 0;
      4'hC: begin p = ua * ub; q = p; r = p >> 16; c = (r & 16'hFFFF) != 0; end
      4'hD: if (ub == 0) begin q = 16'hFFFF; r = ua; dz = 1; end
            else begin q = ua / ub; r = ua % ub; end
      default: ;
    endcase
    return {dz, c, 16'(r), 16'(q)};
  endfunction

  // Called at a negedge; returns at the negedge of the Done cycle (so a following call
  // issues Start in the Done cycle).
  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit scramble, input bit poke);
    logic [33:0] e;
    int n, busy_cnt, exp_lat;
    bit iter;
    e = model(op, a, b);
    iter = (op == 4'hC) || (op == 4'hD && b != 0);
    exp_lat = iter ? W + 1 : 1;
    bus.Start = 1'b1; bus.Ulaop = op; bus.A = a; bus.BusWires = b;
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    if (scramble) begin bus.A = 16'($urandom); bus.BusWires = 16'($urandom); bus.Ulaop = 4'($urandom); end
    n = 1; busy_cnt = 0;
    while (!bus.Done && n < 40) begin
      if (bus.Busy) busy_cnt++;
      if (poke && n == 5) begin bus.Start = 1'b1; bus.Ulaop = 4'h0; end
      else bus.Start = 1'b0;
      @(negedge Clock);
      n++;
    end
    bus.Start = 1'b0;
    chk($sformatf("lat op%0h", op), n, exp_lat);
    chk($sformatf("busycyc op%0h", op), busy_cnt, iter ? W : 0);
    chk($sformatf("busy_done op%0h", op), bus.Busy, 0);
    chk($sformatf("Q op%0h a%0h b%0h", op, a, b), bus.Q, e[15:0]);
    chk($sformatf("Rem op%0h a%0h b%0h", op, a, b), bus.Rem, e[31:16]);
    chk($sformatf("flags op%0h a%0h b%0h", op, a, b),
        {bus.Zero, bus.Neg, bus.Carry, bus.DivZero},
        {e[15:0] == 0, e[15], e[32], e[33]});
  endtask

  initial begin
    int done_seen;
    bus.Start = 1'b0; bus.Ulaop = '0; bus.A = '0; bus.BusWires = '0;
    repeat (2) @(negedge Clock);
    chk("reset outs", {bus.Q, bus.Rem, bus.Done, bus.Busy, bus.Zero, bus.Neg, bus.Carry, bus.DivZero}, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // Abort a MUL with reset after 4 cycles.
    bus.Start = 1'b1; bus.Ulaop = 4'hC; bus.A = 16'd3; bus.BusWires = 16'd5;
    @(posedge Clock);
    @(negedge Clock);
    bus.Start = 1'b0;
    repeat (3) @(negedge Clock);
    chk("busy before abort", bus.Busy, 1);
    Reset = 1'b1;
    #1;
    chk("abort outs", {bus.Q, bus.Rem, bus.Done, bus.Busy, bus.Zero, bus.Neg, bus.Carry, bus.DivZero}, 0);
    @(negedge Clock);
    Reset = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge Clock);
      if (bus.Done) done_seen++;
    end
    chk("no done after abort", done_seen, 0);

    // Directed boundary cases
    do_op(4'h0, 16'hFFFF, 16'h0001, 0, 0);
    do_op(4'h5, 16'h1234, 16'h0002, 0, 0);
    do_op(4'hB, 16'h8000, 16'h0001, 0, 0);
    do_op(4'h2, 16'h8000, 16'h0001, 0, 0);
    do_op(4'hC, 16'h0100, 16'h0300, 1, 1);
    do_op(4'hD, 16'd100, 16'd7, 1, 0);
    do_op(4'hD, 16'd5, 16'd0, 0, 0);
    do_op(4'hD, 16'hFFFF, 16'h0001, 0, 0);  // back-to-back in Done cycle
    do_op(4'h9, 16'h8001, 16'h0001, 0, 0);
    do_op(4'hA, 16'h8001, 16'h0000, 0, 0);
    do_op(4'hA, 16'h0003, 16'h0002, 0, 0);
    do_op(4'hE, 16'h1234, 16'h5678, 0, 0);
    do_op(4'hC, 16'hFFFF, 16'hFFFF, 0, 0);

    // Random ops
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      logic [15:0] a, b;
      op = 4'($urandom);
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 0) @(negedge Clock);
      do_op(op, a, b, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
